// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler.
// MADD/MADDU/MSUB/MSUBU are recognised only when MULDIV_MADD_EN is defined.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic is_start(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_start = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_start = 1'b1;
`endif
            default: is_start = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational 64-bit {HI,LO} result for multiply/divide (and MADD family
// when MULDIV_MADD_EN is defined). Holds all signedness and corner-case rules.
module muldiv_calc
    import muldiv_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res
);

    logic [63:0] w_smul, w_umul;
    logic        w_sdiv;
    logic [31:0] w_ua, w_ub, w_dvs, w_uq, w_ur, w_q, w_r;

    assign w_smul = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_umul = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide runs on magnitudes, then signs are restored:
    // quotient truncates toward zero, remainder follows the dividend.
    assign w_sdiv = (i_op == OP_DIV);
    assign w_ua   = (w_sdiv && i_rs[31]) ? -i_rs : i_rs;
    assign w_ub   = (w_sdiv && i_rt[31]) ? -i_rt : i_rt;
    assign w_dvs  = (w_ub == 32'd0) ? 32'd1 : w_ub;
    assign w_uq   = w_ua / w_dvs;
    assign w_ur   = w_ua % w_dvs;
    assign w_q    = (w_sdiv && (i_rs[31] ^ i_rt[31])) ? -w_uq : w_uq;
    assign w_r    = (w_sdiv && i_rs[31]) ? -w_ur : w_ur;

`ifndef MULDIV_MADD_EN
    logic w_unused_acc;
    assign w_unused_acc = ^{i_hi, i_lo};
`endif

    always_comb begin
        o_res = 64'd0;
        case (i_op)
            OP_MULT:  o_res = w_smul;
            OP_MULTU: o_res = w_umul;
            OP_DIV, OP_DIVU: begin
                if (i_rt == 32'd0)
                    o_res = {i_rs, 32'hFFFF_FFFF};
                else if (w_sdiv && i_rs == 32'h8000_0000 && i_rt == 32'hFFFF_FFFF)
                    o_res = {32'd0, 32'h8000_0000};
                else
                    o_res = {w_r, w_q};
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  o_res = {i_hi, i_lo} + w_smul;
            OP_MADDU: o_res = {i_hi, i_lo} + w_umul;
            OP_MSUB:  o_res = {i_hi, i_lo} - w_smul;
            OP_MSUBU: o_res = {i_hi, i_lo} - w_umul;
`endif
            default:  o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// E-stage HI/LO owner: busy-counter latency model, D-stage stall request,
// flush-aware start. MADD family enabled by MULDIV_MADD_EN.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdRes_E
);

    localparam logic [3:0] LAT_MUL = 4'(MULT_CYCLES);
    localparam logic [3:0] LAT_DIV = 4'(DIV_CYCLES);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_p_hi, r_p_lo, r_hi, r_lo;
    logic [63:0] w_res;
    logic        w_start;

    muldiv_calc u_calc (
        .i_op  (op_E),
        .i_rs  (rs_E),
        .i_rt  (rt_E),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res)
    );

    assign busy    = (r_state == BUSY);
    assign w_start = is_start(op_E) && !Req && !busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = BUSY;
            BUSY:    if (r_cnt == 4'd1) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result is computed at the start edge and held until the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= 4'd0;
            r_p_hi <= 32'd0;
            r_p_lo <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (w_start) begin
            r_p_hi <= w_res[63:32];
            r_p_lo <= w_res[31:0];
            r_cnt  <= is_div(op_E) ? LAT_DIV : LAT_MUL;
        end else if (busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_hi <= r_p_hi;
                r_lo <= r_p_lo;
            end
        end else if (!Req) begin
            if (op_E == OP_MTHI) r_hi <= rs_E;
            if (op_E == OP_MTLO) r_lo <= rs_E;
        end
    end

    assign stall_md = md_D && (busy || w_start);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mdRes_E  = (op_E == OP_MFHI) ? r_hi :
                      (op_E == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: expected {HI,LO} and busy length are
// queued at issue and checked when busy falls.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Req, md_D;
    logic [3:0]  op_E;
    logic [31:0] rs_E, rt_E;
    logic        busy, stall_md;
    logic [31:0] hi, lo, mdRes_E;

    int          n_cmp = 0, n_bad = 0;
    logic [63:0] q_exp[$];
    string       q_tag[$];
    int          q_n[$];
    logic [63:0] m;  // expected architectural {HI,LO}

    logic        mon_prev;
    int          mon_cnt;
    logic [63:0] mon_e;
    string       mon_t;
    int          mon_n;

    muldiv_sched dut (
        .clk(clk), .reset(reset), .Req(Req), .op_E(op_E), .rs_E(rs_E),
        .rt_E(rt_E), .md_D(md_D), .busy(busy), .stall_md(stall_md),
        .hi(hi), .lo(lo), .mdRes_E(mdRes_E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_prev = 1'b0;
            mon_cnt  = 0;
        end else begin
            assert (!(busy && op_E inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}))
                else $error("start-class op issued while busy");
            if (busy) mon_cnt++;
            else if (mon_prev) begin
                if (q_exp.size() == 0) chk("unexpected_commit", {hi, lo}, m);
                else begin
                    mon_e = q_exp.pop_front();
                    mon_t = q_tag.pop_front();
                    mon_n = q_n.pop_front();
                    chk({mon_t, "_hilo"}, {hi, lo}, mon_e);
                    chk({mon_t, "_cyc"}, 64'(mon_cnt), 64'(mon_n));
                end
                mon_cnt = 0;
            end
            mon_prev = busy;
        end
    end

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int n);
        @(negedge clk);
        op_E = op; rs_E = a; rt_E = b;
        q_exp.push_back(exp); q_tag.push_back(tag); q_n.push_back(n);
        m = exp;
        @(negedge clk);
        op_E = OP_NONE;
    endtask

    task automatic wait_sb();
        int k = 0;
        while ((q_exp.size() != 0 || busy) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) chk("timeout_pending", 64'(q_exp.size()), 64'd0);
    endtask

    // Op that must not start: no stall, no busy, HI/LO unchanged.
    task automatic nostart(input string tag, input logic [3:0] op, input logic req);
        @(negedge clk);
        op_E = op; rs_E = 32'd3; rt_E = 32'd4; Req = req; md_D = 1'b1;
        #1 chk({tag, "_stall"}, 64'(stall_md), 64'd0);
        @(negedge clk);
        op_E = OP_NONE; Req = 1'b0; md_D = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, m);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        op_E = op; rs_E = v;
        if (op == OP_MTHI) m[63:32] = v; else m[31:0] = v;
        @(negedge clk);
        op_E = OP_NONE;
    endtask

    initial begin
        reset = 1'b0; Req = 1'b0; md_D = 1'b0; op_E = OP_NONE; rs_E = '0; rt_E = '0; m = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall_md), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5); wait_sb();
        issue("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, {32'h2, 32'hFFFF_FFFA}, 5); wait_sb();
        issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10); wait_sb();
        issue("divu_z", OP_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 10); wait_sb();
        issue("div_z", OP_DIV, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 10); wait_sb();
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10); wait_sb();

        nostart("req_mult", OP_MULT, 1'b1);
        nostart("req_mtlo", OP_MTLO, 1'b1);

        issue("req_in_busy", OP_MULT, 32'd7, 32'd6, {32'd0, 32'd42}, 5);
        Req = 1'b1;
        repeat (2) @(negedge clk);
        Req = 1'b0;
        wait_sb();

        // Stall from the start cycle through the last busy cycle.
        md_D = 1'b1;
        @(negedge clk);
        op_E = OP_MULT; rs_E = 32'd2; rt_E = 32'd2;
        q_exp.push_back({32'd0, 32'd4}); q_tag.push_back("stall_mult"); q_n.push_back(5);
        m = {32'd0, 32'd4};
        #1 chk("stall_start", 64'(stall_md), 64'd1);
        @(negedge clk);
        op_E = OP_NONE;
        for (int k = 0; k < 5; k++) begin
            chk("stall_busy", 64'(stall_md), 64'd1);
            @(negedge clk);
        end
        chk("stall_end", 64'(stall_md), 64'd0);
        md_D = 1'b0;
        wait_sb();

        mt(OP_MTLO, 32'h1234);
        chk("mtlo", 64'(lo), 64'h1234);
        op_E = OP_MFLO;
        #1 chk("mflo_res", 64'(mdRes_E), 64'h1234);
        mt(OP_MTHI, 32'hABCD);
        chk("mthi_hilo", {hi, lo}, m);
        op_E = OP_MFHI;
        #1 chk("mfhi_res", 64'(mdRes_E), 64'hABCD);
        op_E = OP_NONE;
        #1 chk("none_res", 64'(mdRes_E), 64'd0);

        mt(OP_MTHI, 32'd0);
        mt(OP_MTLO, 32'd10);
`ifdef MULDIV_MADD_EN
        issue("madd", OP_MADD, 32'd3, 32'd4, {32'd0, 32'd22}, 5); wait_sb();
        issue("msubu", OP_MSUBU, 32'd1, 32'd30, {32'hFFFF_FFFF, 32'hFFFF_FFF8}, 5); wait_sb();
`else
        nostart("madd_off", OP_MADD, 1'b0);
        nostart("msubu_off", OP_MSUBU, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            automatic logic [31:0] a = $urandom;
            automatic logic [31:0] b = $urandom;
            automatic int unsigned kind = $urandom_range(0, 3);
            automatic int sa, sb;
            if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
            sa = int'(a); sb = int'(b);
            case (kind)
                0: issue("rnd_mult", OP_MULT, a, b, 64'(longint'(sa) * longint'(sb)), 5);
                1: issue("rnd_multu", OP_MULTU, a, b, 64'(a) * 64'(b), 5);
                2: issue("rnd_div", OP_DIV, a, b, {32'(sa % sb), 32'(sa / sb)}, 10);
                default: issue("rnd_divu", OP_DIVU, a, b, {a % b, a / b}, 10);
            endcase
            wait_sb();
        end

        // Reset in the middle of a divide (cnt 6) discards it.
        @(negedge clk);
        op_E = OP_DIV; rs_E = 32'd100; rt_E = 32'd7;
        @(negedge clk);
        op_E = OP_NONE;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        m = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue("post_rst_mult", OP_MULT, 32'd9, 32'd9, {32'd0, 32'd81}, 5); wait_sb();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
